// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory bus seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus memory).
interface mem_port_arbiter_if #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16
);
  logic                 req0, we0, gnt0, done0;
  logic [BITS_ADDR-1:0] addr0;
  logic [BITS_DATA-1:0] wdata0, rdata0;
  logic                 req1, we1, gnt1, done1;
  logic [BITS_ADDR-1:0] addr1;
  logic [BITS_DATA-1:0] wdata1, rdata1;
  logic [BITS_ADDR-1:0] MAR;
  logic [BITS_DATA-1:0] MBR_W, MBR_R;
  logic                 write, busy, owner;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, MBR_R,
    output gnt0, done0, rdata0, gnt1, done1, rdata1, MAR, MBR_W, write, busy, owner
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, MBR_R,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1, MAR, MBR_W, write, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port main memory bus.
// One transaction occupies READ_LAT+2 cycles: grant, READ_LAT-1 wait cycles, done, back to idle.
module mem_port_arbiter #(
  parameter int BITS_DATA = 32,
  parameter int BITS_ADDR = 16,
  parameter int READ_LAT  = 1
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [BITS_ADDR-1:0] mar_q, mar_d;
  logic [BITS_DATA-1:0] mbrw_q, mbrw_d;
  logic [BITS_DATA-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                 we_q, we_d, write_q, write_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                 done0_q, done0_d, done1_q, done1_d;
  logic                 busy_q, busy_d, owner_q, owner_d, last_q, last_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pick;

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mbrw_d   = mbrw_q;
    we_d     = we_q;
    write_d  = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    busy_d   = busy_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    // On a tie the port that did not win last time goes next.
    pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          mar_d   = pick ? bus.addr1 : bus.addr0;
          mbrw_d  = pick ? bus.wdata1 : bus.wdata0;
          we_d    = pick ? bus.we1 : bus.we0;
          write_d = pick ? bus.we1 : bus.we0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          owner_d = pick;
          last_d  = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          if (owner_q) begin
            done1_d = 1'b1;
            if (!we_q) rdata1_d = bus.MBR_R;
          end else begin
            done0_d = 1'b1;
            if (!we_q) rdata0_d = bus.MBR_R;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      mar_q    <= '0;
      mbrw_q   <= '0;
      we_q     <= 1'b0;
      write_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mar_q    <= mar_d;
      mbrw_q   <= mbrw_d;
      we_q     <= we_d;
      write_q  <= write_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.MAR    = mar_q;
  assign bus.MBR_W  = mbrw_q;
  assign bus.write  = write_q;
  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.rdata0 = rdata0_q;
  assign bus.rdata1 = rdata1_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

  a_gnt_onehot:  assert property (@(posedge clk) !(gnt0_q && gnt1_q));
  a_done_onehot: assert property (@(posedge clk) !(done0_q && done1_q));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: READ_LAT=1 instance against a memory model with a scoreboard,
// plus a READ_LAT=3 instance whose MBR_R is driven directly.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.BITS_DATA(32), .BITS_ADDR(16)) ifa ();
  mem_port_arbiter_if #(.BITS_DATA(32), .BITS_ADDR(16)) ifb ();

  mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .READ_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  mem_port_arbiter #(.BITS_DATA(32), .BITS_ADDR(16), .READ_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  // memory model for the READ_LAT=1 instance: combinational read, write on posedge
  logic [31:0] mem    [0:65535];
  logic [31:0] shadow [0:65535];
  assign ifa.MBR_R = mem[ifa.MAR];
  always @(posedge clk) if (ifa.write) mem[ifa.MAR] <= ifa.MBR_W;

  typedef struct { bit port; bit we; logic [31:0] rdata; } exp_t;
  exp_t sbq[$];
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

  task automatic push(input bit port, input bit we, input logic [15:0] addr, input logic [31:0] wd);
    exp_t e;
    e.port = port; e.we = we;
    if (we) begin
      shadow[addr] = wd;
      e.rdata = port ? exp_rd1 : exp_rd0;
    end else begin
      e.rdata = shadow[addr];
      if (port) exp_rd1 = shadow[addr]; else exp_rd0 = shadow[addr];
    end
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ifa.done0 || ifa.done1) begin
      chk_cnt++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected_done: got done0=%0b done1=%0b want none", ifa.done0, ifa.done1);
      end else begin
        exp_t e;
        logic [31:0] act;
        e = sbq.pop_front();
        if (ifa.done1 !== e.port)
          $display("FAIL sb_done_port: got port %0b want %0b", ifa.done1, e.port);
        else pass_cnt++;
        chk_cnt++;
        act = e.port ? ifa.rdata1 : ifa.rdata0;
        if (act !== e.rdata)
          $display("FAIL sb_rdata: got %h want %h (port %0b we %0b)", act, e.rdata, e.port, e.we);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    while (!(ifa.gnt0 || ifa.gnt1) && n < budget) begin tick(); n++; end
    chk_cnt++;
    if (!(ifa.gnt0 || ifa.gnt1)) $display("FAIL gnt_timeout: got no grant want grant within %0d", budget);
    else pass_cnt++;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(ifa.done0 || ifa.done1) && n < budget) begin tick(); n++; end
    chk_cnt++;
    if (!(ifa.done0 || ifa.done1)) $display("FAIL done_timeout: got no done want done within %0d", budget);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    chk_cnt++;
    if ({ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.write, ifa.busy, ifa.owner} !== 7'b0)
      $display("FAIL rst_ctrl: got %b want 0000000",
               {ifa.gnt0, ifa.gnt1, ifa.done0, ifa.done1, ifa.write, ifa.busy, ifa.owner});
    else pass_cnt++;
    chk_cnt++;
    if (ifa.MAR !== 16'h0 || ifa.MBR_W !== 32'h0)
      $display("FAIL rst_bus: got MAR=%h MBR_W=%h want 0 0", ifa.MAR, ifa.MBR_W);
    else pass_cnt++;
    chk_cnt++;
    if (ifa.rdata0 !== 32'h0 || ifa.rdata1 !== 32'h0 || ifb.rdata0 !== 32'h0)
      $display("FAIL rst_rdata: got %h %h %h want 0", ifa.rdata0, ifa.rdata1, ifb.rdata0);
    else pass_cnt++;
    exp_rd0 = '0; exp_rd1 = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read_port0();
    ifa.we0 = 1'b0; ifa.addr0 = 16'h0010; ifa.req0 = 1'b1;
    push(1'b0, 1'b0, 16'h0010, 32'h0);
    tick();
    chk_cnt++;
    if (ifa.gnt0 !== 1'b1 || ifa.gnt1 !== 1'b0 || ifa.MAR !== 16'h0010 || ifa.write !== 1'b0 || ifa.owner !== 1'b0)
      $display("FAIL rd_grant: got gnt0=%0b gnt1=%0b MAR=%h write=%0b owner=%0b want 1 0 0010 0 0",
               ifa.gnt0, ifa.gnt1, ifa.MAR, ifa.write, ifa.owner);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ifa.done0 !== 1'b1 || ifa.gnt0 !== 1'b0 || ifa.rdata0 !== 32'hDEADBEEF)
      $display("FAIL rd_done: got done0=%0b gnt0=%0b rdata0=%h want 1 0 deadbeef", ifa.done0, ifa.gnt0, ifa.rdata0);
    else pass_cnt++;
    ifa.req0 = 1'b0;
    tick();
    chk_cnt++;
    if (ifa.busy !== 1'b0 || ifa.done0 !== 1'b0)
      $display("FAIL rd_idle: got busy=%0b done0=%0b want 0 0", ifa.busy, ifa.done0);
    else pass_cnt++;
  endtask

  task automatic test_write_port1();
    ifa.we1 = 1'b1; ifa.addr1 = 16'h0200; ifa.wdata1 = 32'h12345678; ifa.req1 = 1'b1;
    push(1'b1, 1'b1, 16'h0200, 32'h12345678);
    tick();
    chk_cnt++;
    if (ifa.write !== 1'b1 || ifa.gnt1 !== 1'b1 || ifa.MAR !== 16'h0200 || ifa.MBR_W !== 32'h12345678)
      $display("FAIL wr_cycle: got write=%0b gnt1=%0b MAR=%h MBR_W=%h want 1 1 0200 12345678",
               ifa.write, ifa.gnt1, ifa.MAR, ifa.MBR_W);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ifa.write !== 1'b0 || ifa.done1 !== 1'b1 || ifa.rdata1 !== 32'h0)
      $display("FAIL wr_done: got write=%0b done1=%0b rdata1=%h want 0 1 0", ifa.write, ifa.done1, ifa.rdata1);
    else pass_cnt++;
    ifa.req1 = 1'b0; ifa.we1 = 1'b0;
    tick();
    ifa.we0 = 1'b0; ifa.addr0 = 16'h0200; ifa.req0 = 1'b1;
    push(1'b0, 1'b0, 16'h0200, 32'h0);
    wait_gnt(5);
    wait_done(5);
    ifa.req0 = 1'b0;
    chk_cnt++;
    if (ifa.rdata0 !== 32'h12345678 || ifa.rdata1 !== 32'h0)
      $display("FAIL wr_readback: got rdata0=%h rdata1=%h want 12345678 0", ifa.rdata0, ifa.rdata1);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int prev_done = 0;
    test_reset();
    ifa.we0 = 1'b0; ifa.addr0 = 16'h0020; ifa.we1 = 1'b0; ifa.addr1 = 16'h0030;
    ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    for (int i = 0; i < 4; i++) push(i[0], 1'b0, i[0] ? 16'h0030 : 16'h0020, 32'h0);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(6);
      chk_cnt++;
      if (ifa.gnt1 !== i[0] || ifa.gnt0 === ifa.gnt1)
        $display("FAIL rr_order_%0d: got gnt0=%0b gnt1=%0b want port %0d", i, ifa.gnt0, ifa.gnt1, i[0]);
      else pass_cnt++;
      if (i == 3) begin ifa.req0 = 1'b0; ifa.req1 = 1'b0; end
      wait_done(6);
      if (i > 0) begin
        chk_cnt++;
        if (cyc - prev_done !== 3)
          $display("FAIL rr_spacing_%0d: got %0d cycles want 3", i, cyc - prev_done);
        else pass_cnt++;
      end
      prev_done = cyc;
      if (i < 3) tick();
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    ifa.we1 = 1'b1; ifa.addr1 = 16'h0300; ifa.wdata1 = 32'h0BADF00D; ifa.req1 = 1'b1;
    tick();
    chk_cnt++;
    if (ifa.gnt1 !== 1'b1 || ifa.write !== 1'b1)
      $display("FAIL rm_grant: got gnt1=%0b write=%0b want 1 1", ifa.gnt1, ifa.write);
    else pass_cnt++;
    reset = 1'b0; ifa.req1 = 1'b0; ifa.we1 = 1'b0;
    tick();
    chk_cnt++;
    if (ifa.write !== 1'b0 || ifa.busy !== 1'b0 || ifa.done1 !== 1'b0 || ifa.gnt1 !== 1'b0 || ifa.owner !== 1'b0)
      $display("FAIL rm_state: got write=%0b busy=%0b done1=%0b gnt1=%0b owner=%0b want 0 0 0 0 0",
               ifa.write, ifa.busy, ifa.done1, ifa.gnt1, ifa.owner);
    else pass_cnt++;
    exp_rd0 = '0; exp_rd1 = '0;
    reset = 1'b1;
    tick(); tick();
    ifa.addr0 = 16'h0060; ifa.addr1 = 16'h0070; ifa.req0 = 1'b1; ifa.req1 = 1'b1;
    push(1'b0, 1'b0, 16'h0060, 32'h0);
    push(1'b1, 1'b0, 16'h0070, 32'h0);
    wait_gnt(5);
    chk_cnt++;
    if (ifa.gnt0 !== 1'b1)
      $display("FAIL rm_tie: got gnt0=%0b gnt1=%0b want gnt0", ifa.gnt0, ifa.gnt1);
    else pass_cnt++;
    wait_done(5);
    ifa.req0 = 1'b0;
    tick();
    wait_gnt(5);
    wait_done(5);
    ifa.req1 = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    ifa.we0 = 1'b0; ifa.addr0 = 16'h0040; ifa.req0 = 1'b1;
    push(1'b0, 1'b0, 16'h0040, 32'h0);
    tick();
    ifa.req0 = 1'b0; ifa.addr0 = 16'h0050; ifa.we0 = 1'b1;
    chk_cnt++;
    if (ifa.gnt0 !== 1'b1 || ifa.MAR !== 16'h0040)
      $display("FAIL ac_grant: got gnt0=%0b MAR=%h want 1 0040", ifa.gnt0, ifa.MAR);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (ifa.done0 !== 1'b1 || ifa.MAR !== 16'h0040 || ifa.write !== 1'b0)
      $display("FAIL ac_done: got done0=%0b MAR=%h write=%0b want 1 0040 0", ifa.done0, ifa.MAR, ifa.write);
    else pass_cnt++;
    ifa.we0 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lat3();
    ifb.we0 = 1'b0; ifb.addr0 = 16'h0011; ifb.req0 = 1'b1; ifb.MBR_R = 32'hBAD0BAD0;
    tick();
    chk_cnt++;
    if (ifb.gnt0 !== 1'b1 || ifb.MAR !== 16'h0011)
      $display("FAIL l3_grant: got gnt0=%0b MAR=%h want 1 0011", ifb.gnt0, ifb.MAR);
    else pass_cnt++;
    ifb.MBR_R = 32'hBAD1BAD1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk_cnt++;
      if (ifb.done0 !== 1'b0 || ifb.busy !== 1'b1)
        $display("FAIL l3_wait_%0d: got done0=%0b busy=%0b want 0 1", i, ifb.done0, ifb.busy);
      else pass_cnt++;
    end
    ifb.MBR_R = 32'hCAFEF00D;
    tick();
    chk_cnt++;
    if (ifb.done0 !== 1'b1 || ifb.rdata0 !== 32'hCAFEF00D)
      $display("FAIL l3_done: got done0=%0b rdata0=%h want 1 cafef00d", ifb.done0, ifb.rdata0);
    else pass_cnt++;
    ifb.req0 = 1'b0; ifb.MBR_R = 32'hBAD2BAD2;
    tick();
    chk_cnt++;
    if (ifb.done0 !== 1'b0 || ifb.busy !== 1'b0 || ifb.rdata0 !== 32'hCAFEF00D)
      $display("FAIL l3_idle: got done0=%0b busy=%0b rdata0=%h want 0 0 cafef00d", ifb.done0, ifb.busy, ifb.rdata0);
    else pass_cnt++;
  endtask

  initial begin
    for (int unsigned i = 0; i < 65536; i++) begin
      mem[i]    = 32'hA5A50000 | i;
      shadow[i] = 32'hA5A50000 | i;
    end
    mem[16'h0010] = 32'hDEADBEEF;
    shadow[16'h0010] = 32'hDEADBEEF;
    {ifa.req0, ifa.we0, ifa.req1, ifa.we1} = '0;
    ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    {ifb.req0, ifb.we0, ifb.req1, ifb.we1} = '0;
    ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0; ifb.MBR_R = '0;
    #1;
    test_reset();
    test_read_port0();
    test_write_port1();
    test_back_to_back();
    test_reset_mid();
    test_addr_change();
    test_lat3();
    tick();
    chk_cnt++;
    if (sbq.size() != 0) $display("FAIL sb_leftover: got %0d pending want 0", sbq.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
